// File: rtl/count_session_ctrl.sv
// Session controller for a shared 3-bit event counter: round-robin grant, clear, count window,
// then report the saturated count and an overflow flag with a one-cycle done pulse.
module count_session_ctrl #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [WIN_W-1:0] win_len,
  input  logic             event_in,
  input  logic [2:0]       cnt_val,
  output logic             cnt_clear,
  output logic             cnt_inc,
  output logic [NREQ-1:0]  grant,
  output logic             busy,
  output logic [NREQ-1:0]  done,
  output logic [2:0]       result,
  output logic             overflow
);

  localparam int unsigned LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {StIdle, StClear, StCount, StSettle, StDone} state_e;

  state_e           state;
  logic [NREQ-1:0]  pending;
  logic [LW-1:0]    last;
  logic [WIN_W-1:0] timer;
  logic             ovf;

  logic             found;
  logic [LW-1:0]    win_idx;
  logic [NREQ-1:0]  win_oh;
  int unsigned      idx_int;
  logic [LW-1:0]    idx;

  // Round-robin search starting one past the last winner.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    idx_int = 0;
    idx     = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx_int = (32'(last) + 32'd1 + 32'(k)) % NREQ;
      idx     = LW'(idx_int);
      if (!found && pending[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    win_oh = found ? (NREQ'(1) << win_idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= StIdle;
      grant    <= '0;
      pending  <= '0;
      last     <= LW'(NREQ - 1);
      timer    <= '0;
      ovf      <= 1'b0;
      result   <= 3'd0;
      overflow <= 1'b0;
    end else begin
      // A new request in the grant cycle survives the clear.
      pending <= (pending & ~((state == StIdle) ? win_oh : '0)) | req;
      unique case (state)
        StIdle: begin
          if (found) begin
            grant <= win_oh;
            last  <= win_idx;
            timer <= (win_len == '0) ? WIN_W'(1) : win_len;
            ovf   <= 1'b0;
            state <= StClear;
          end
        end
        StClear: state <= StCount;
        StCount: begin
          if (event_in && (cnt_val == 3'd7)) ovf <= 1'b1;
          if (timer == WIN_W'(1)) state <= StSettle;
          else                    timer <= timer - WIN_W'(1);
        end
        StSettle: begin
          result   <= cnt_val;
          overflow <= ovf;
          state    <= StDone;
        end
        StDone: begin
          grant <= '0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_clear = (state == StClear);
    cnt_inc   = (state == StCount) && event_in && (cnt_val != 3'd7);
    busy      = (state != StIdle);
    done      = (state == StDone) ? grant : '0;
  end

endmodule

// File: tb/tb_count_session_ctrl.sv
// Bench for count_session_ctrl with a behavioural wrapping 3-bit counter attached.
module tb_count_session_ctrl;

  localparam int NREQ  = 4;
  localparam int WIN_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NREQ-1:0]  req = '0;
  logic [WIN_W-1:0] win_len = '0;
  logic             event_in = 1'b0;
  logic [2:0]       cnt_val = 3'd0;
  logic             cnt_clear, cnt_inc, busy, overflow;
  logic [NREQ-1:0]  grant, done;
  logic [2:0]       result;

  count_session_ctrl #(.NREQ(NREQ), .WIN_W(WIN_W)) dut (
    .clk(clk), .reset(reset), .req(req), .win_len(win_len), .event_in(event_in),
    .cnt_val(cnt_val), .cnt_clear(cnt_clear), .cnt_inc(cnt_inc), .grant(grant),
    .busy(busy), .done(done), .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Plain counter: wraps on its own, so any unsaturated increment shows up.
  always @(posedge clk) begin
    if (cnt_clear)    cnt_val <= 3'd0;
    else if (cnt_inc) cnt_val <= cnt_val + 3'd1;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NREQ-1:0]  r;
    logic [WIN_W-1:0] win;
    logic [15:0]      ev;
    logic [2:0]       res;
    logic             ovf;
  } vec_t;

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] r;
  } pulse_t;

  vec_t            vecs[7];
  pulse_t          pq[$];
  logic [NREQ-1:0] done_q[$];
  logic [NREQ-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; req = '0; event_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // One session from idle with empty pending; checks every cycle against the timing model.
  task automatic run_vec(input int n, input vec_t v);
    int   w;
    logic in_count;
    w = (v.win == '0) ? 1 : int'(v.win);
    win_len = v.win;
    for (int c = 0; c <= 5 + w; c++) begin
      @(posedge clk); #1;
      req      = (c == 0) ? v.r : '0;
      in_count = (c >= 3) && (c <= 2 + w);
      event_in = in_count ? v.ev[4'(c - 3)] : 1'b0;
      #2;
      chk($sformatf("v%0d_c%0d_clear", n, c), cnt_clear, (c == 2));
      chk($sformatf("v%0d_c%0d_inc", n, c), cnt_inc, in_count && event_in && (cnt_val != 3'd7));
      chk($sformatf("v%0d_c%0d_busy", n, c), busy, (c >= 2) && (c <= 4 + w));
      chk($sformatf("v%0d_c%0d_grant", n, c), grant, ((c >= 2) && (c <= 4 + w)) ? v.r : '0);
      chk($sformatf("v%0d_c%0d_done", n, c), done, (c == 4 + w) ? v.r : '0);
      if (c == 4 + w) begin
        chk($sformatf("v%0d_result", n), result, v.res);
        chk($sformatf("v%0d_overflow", n), overflow, v.ovf);
      end
    end
    event_in = 1'b0;
  endtask

  // Free-running window: applies queued req pulses and records every done value.
  task automatic run_collect(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      req = '0;
      foreach (pq[i]) if (pq[i].cyc == c) req = req | pq[i].r;
      #2;
      if (done != '0) done_q.push_back(done);
      if (cnt_clear && cnt_inc) chk("clear_inc_exclusive", {cnt_clear, cnt_inc}, 2'b00);
    end
    req = '0;
    pq.delete();
  endtask

  task automatic cmp_done(input string name);
    chk({name, "_num_sessions"}, done_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < done_q.size(); i++)
      chk($sformatf("%s_session%0d", name, i), done_q[i], exp_q[i]);
    done_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{r: 4'b0001, win: 8'd5,  ev: 16'b10101,  res: 3'd3, ovf: 1'b0};
    vecs[1] = '{r: 4'b0100, win: 8'd12, ev: 16'hFFFF,   res: 3'd7, ovf: 1'b1};
    vecs[2] = '{r: 4'b0010, win: 8'd0,  ev: 16'hFFFF,   res: 3'd1, ovf: 1'b0};
    vecs[3] = '{r: 4'b1000, win: 8'd7,  ev: 16'hFFFF,   res: 3'd7, ovf: 1'b0};
    vecs[4] = '{r: 4'b0001, win: 8'd8,  ev: 16'hFFFF,   res: 3'd7, ovf: 1'b1};
    vecs[5] = '{r: 4'b0010, win: 8'd3,  ev: 16'h0000,   res: 3'd0, ovf: 1'b0};
    vecs[6] = '{r: 4'b0100, win: 8'd1,  ev: 16'h0000,   res: 3'd0, ovf: 1'b0};

    do_reset();
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, '0);
    chk("rst_done", done, '0);
    chk("rst_result", result, 3'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_clear", cnt_clear, 1'b0);
    chk("rst_inc", cnt_inc, 1'b0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Round-robin order from reset, then a fresh pair after serving index 3.
    do_reset();
    win_len = 8'd2;
    pq.push_back('{cyc: 0, r: 4'b1011});
    run_collect(40);
    exp_q = '{4'b0001, 4'b0010, 4'b1000};
    cmp_done("rr_1011");
    pq.push_back('{cyc: 0, r: 4'b0011});
    run_collect(30);
    exp_q = '{4'b0001, 4'b0010};
    cmp_done("rr_0011");

    // Reset during COUNT with another request pending.
    do_reset();
    win_len = 8'd6;
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      req      = (c == 0) ? 4'b0100 : ((c == 3) ? 4'b1000 : 4'b0000);
      event_in = 1'b1;
      reset    = (c == 4);
    end
    @(posedge clk); #1;
    reset = 1'b0; req = '0; event_in = 1'b0;
    #2;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_grant", grant, '0);
    chk("midrst_done", done, '0);
    chk("midrst_clear", cnt_clear, 1'b0);
    run_collect(20);
    cmp_done("midrst_no_session");
    pq.push_back('{cyc: 0, r: 4'b0101});
    run_collect(40);
    exp_q = '{4'b0001, 4'b0100};
    cmp_done("midrst_fresh");

    // Requester 0 re-requests during its session while 2 waits.
    do_reset();
    win_len = 8'd2;
    pq.push_back('{cyc: 0, r: 4'b0001});
    pq.push_back('{cyc: 3, r: 4'b0100});
    pq.push_back('{cyc: 5, r: 4'b0001});
    run_collect(40);
    exp_q = '{4'b0001, 4'b0100, 4'b0001};
    cmp_done("rerequest");

    // req[1] again in the cycle it wins arbitration: one more session.
    do_reset();
    win_len = 8'd2;
    pq.push_back('{cyc: 0, r: 4'b0010});
    pq.push_back('{cyc: 1, r: 4'b0010});
    run_collect(30);
    exp_q = '{4'b0010, 4'b0010};
    cmp_done("set_wins");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
